// File: rtl/button_press_decoder.sv
// Classifies a debounced button level into short-press, long-press and
// double-click pulses using one shared timer and a six-state FSM.
module button_press_decoder #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int LONG_MS   = 1000,
   parameter int DOUBLE_MS = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic busy
);

   localparam int LONG_COUNT   = (CLK_FREQ / 1000) * LONG_MS;
   localparam int DOUBLE_COUNT = (CLK_FREQ / 1000) * DOUBLE_MS;
   localparam int MAX_COUNT    = (LONG_COUNT > DOUBLE_COUNT) ? LONG_COUNT : DOUBLE_COUNT;
   localparam int CW           = $clog2(MAX_COUNT + 1);

   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_COUNT - 1);
   localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_COUNT - 1);

   typedef enum logic [2:0] {
      ARM,
      IDLE,
      PRESSED,
      LONG_HELD,
      WAIT_SECOND,
      SECOND_PRESSED
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          short_q, short_d;
   logic          long_q, long_d;
   logic          double_q, double_d;
   logic          busy_q, busy_d;
   logic          event_active;

   // The cycle an event pulse is visible, IDLE refuses a new press.
   assign event_active = short_q | long_q | double_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;

      unique case (state_q)
         ARM: begin
            if (!btn_level) state_d = IDLE;
         end
         IDLE: begin
            if (btn_level && !event_active) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end
         end
         PRESSED: begin
            if (!btn_level) begin
               state_d = WAIT_SECOND;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LONG_HELD: begin
            if (!btn_level) state_d = IDLE;
         end
         WAIT_SECOND: begin
            // A press on the timeout edge still counts as the second click.
            if (btn_level) begin
               state_d = SECOND_PRESSED;
            end else if (cnt_q == DOUBLE_LAST) begin
               state_d = IDLE;
               short_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SECOND_PRESSED: begin
            if (!btn_level) begin
               state_d  = IDLE;
               double_d = 1'b1;
            end
         end
         default: state_d = ARM;
      endcase

      busy_d = (state_d == PRESSED) || (state_d == LONG_HELD) ||
               (state_d == WAIT_SECOND) || (state_d == SECOND_PRESSED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARM;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         long_q   <= long_d;
         double_q <= double_d;
         busy_q   <= busy_d;
      end
   end

   assign short_press  = short_q;
   assign long_press   = long_q;
   assign double_click = double_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Self-checking bench for button_press_decoder: directed gesture scenarios plus
// random button activity, compared against a timestamp-based gesture model.
module tb_button_press_decoder;

   localparam int LONG = 8;
   localparam int DC   = 4;

   logic clk = 1'b0;
   logic rst;
   logic btn_level;
   logic short_press, long_press, double_click, busy;

   int checks   = 0;
   int failures = 0;

   button_press_decoder #(
      .CLK_FREQ (1000),
      .LONG_MS  (8),
      .DOUBLE_MS(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_level   (btn_level),
      .short_press (short_press),
      .long_press  (long_press),
      .double_click(double_click),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Gesture model: tracks press/release edge numbers and decides events by elapsed time.
   int   t;
   bit   m_armed, m_active, m_second, m_released, m_long_done;
   int   m_press, m_rel, m_last_ev;
   logic e_short, e_long, e_double, e_busy;

   task automatic model_reset();
      m_armed     = 1'b0;
      m_active    = 1'b0;
      m_second    = 1'b0;
      m_released  = 1'b0;
      m_long_done = 1'b0;
      m_last_ev   = -10;
      e_short     = 1'b0;
      e_long      = 1'b0;
      e_double    = 1'b0;
      e_busy      = 1'b0;
   endtask

   task automatic model_step(input logic b);
      t++;
      e_short  = 1'b0;
      e_long   = 1'b0;
      e_double = 1'b0;
      if (!m_armed) begin
         if (!b) m_armed = 1'b1;
      end else if (!m_active) begin
         if (b && t != m_last_ev + 1) begin
            m_active    = 1'b1;
            m_second    = 1'b0;
            m_released  = 1'b0;
            m_long_done = 1'b0;
            m_press     = t;
         end
      end else if (m_second) begin
         if (!b) begin
            e_double  = 1'b1;
            m_active  = 1'b0;
            m_last_ev = t;
         end
      end else if (!m_released) begin
         if (b) begin
            if (!m_long_done && t - m_press == LONG) begin
               e_long      = 1'b1;
               m_long_done = 1'b1;
               m_last_ev   = t;
            end
         end else if (m_long_done) begin
            m_active = 1'b0;
         end else begin
            m_released = 1'b1;
            m_rel      = t;
         end
      end else begin
         if (b && t - m_rel <= DC) begin
            m_second = 1'b1;
         end else if (t - m_rel == DC) begin
            e_short   = 1'b1;
            m_active  = 1'b0;
            m_last_ev = t;
         end
      end
      e_busy = m_active;
   endtask

   task automatic cycle(input logic b);
      btn_level = b;
      @(posedge clk);
      #1;
      model_step(b);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0);
   endtask

   task automatic do_reset_release();
      @(posedge clk);
      #4;
      rst = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      btn_level = 1'b0;
      t         = 0;
      model_reset();
      #3;
      checks++;
      if ({short_press, long_press, double_click, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0000", {short_press, long_press, double_click, busy});
      end
      @(posedge clk);
      do_reset_release();
      idle_cycles(2);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_short();
      int n = 0, at = -1;
      idle_cycles(2);
      for (int i = 0; i < 9; i++) begin
         cycle(i < 3);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL short_cyc%0d got=%b exp=%b", i, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
         if (short_press) begin n++; at = i; end
      end
      checks++;
      if (n != 1 || at != 7) begin
         failures++;
         $display("FAIL short_timing got count=%0d edge=%0d exp count=1 edge=7", n, at);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL short_busy_end got=%b exp=0", busy);
      end
   endtask

   task automatic test_long();
      int n = 0, at = -1, other = 0;
      idle_cycles(2);
      for (int i = 0; i < 15; i++) begin
         cycle(i < 12);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL long_cyc%0d got=%b exp=%b", i, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
         if (long_press) begin n++; at = i; end
         if (short_press || double_click) other++;
      end
      checks++;
      if (n != 1 || at != 8 || other != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL long_timing got count=%0d edge=%0d other=%0d busy=%b exp count=1 edge=8 other=0 busy=0",
                  n, at, other, busy);
      end
   endtask

   task automatic test_double();
      logic [10:0] pat = 11'b000_0011_0011;
      int n = 0, at = -1, shorts = 0;
      idle_cycles(2);
      for (int i = 0; i < 11; i++) begin
         cycle(pat[i]);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL double_cyc%0d got=%b exp=%b", i, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
         if (double_click) begin n++; at = i; end
         if (short_press) shorts++;
      end
      checks++;
      if (n != 1 || at != 6 || shorts != 0) begin
         failures++;
         $display("FAIL double_timing got count=%0d edge=%0d shorts=%0d exp count=1 edge=6 shorts=0", n, at, shorts);
      end
   endtask

   task automatic test_boundary();
      logic [11:0] pat_a = 12'b0000_0110_0001;
      logic [19:0] pat_b = 20'b0000_0000_0001_1100_0001;
      int shorts = 0, doubles = 0, short_at = -1;
      logic busy_at7 = 1'b0;
      idle_cycles(2);
      for (int i = 0; i < 12; i++) begin
         cycle(pat_a[i]);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL bound_a_cyc%0d got=%b exp=%b", i, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
         if (short_press) shorts++;
         if (double_click) doubles++;
      end
      checks++;
      if (shorts != 0 || doubles != 1) begin
         failures++;
         $display("FAIL bound_press_wins got shorts=%0d doubles=%0d exp shorts=0 doubles=1", shorts, doubles);
      end
      idle_cycles(2);
      shorts = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(pat_b[i]);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL bound_b_cyc%0d got=%b exp=%b", i, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
         if (short_press) begin shorts++; if (short_at < 0) short_at = i; end
         if (i == 7) busy_at7 = busy;
      end
      checks++;
      if (short_at != 5 || busy_at7 !== 1'b1 || shorts != 2) begin
         failures++;
         $display("FAIL bound_timeout got short_edge=%0d busy7=%b shorts=%0d exp short_edge=5 busy7=1 shorts=2",
                  short_at, busy_at7, shorts);
      end
   endtask

   task automatic test_reset_held();
      int events = 0, busys = 0, shorts = 0;
      idle_cycles(2);
      btn_level = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({short_press, long_press, double_click, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL held_reset_outputs got=%b exp=0000", {short_press, long_press, double_click, busy});
      end
      do_reset_release();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL held_cyc%0d got=%b exp=%b", i, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
         if (short_press || long_press || double_click) events++;
         if (busy) busys++;
      end
      checks++;
      if (events != 0 || busys != 0) begin
         failures++;
         $display("FAIL held_through_reset got events=%0d busy_cycles=%0d exp 0 0", events, busys);
      end
      idle_cycles(2);
      for (int i = 0; i < 9; i++) begin
         cycle(i < 3);
         if (short_press) shorts++;
      end
      checks++;
      if (shorts != 1) begin
         failures++;
         $display("FAIL held_then_normal got shorts=%0d exp=1", shorts);
      end
   endtask

   task automatic test_mid_reset();
      int longs = 0;
      idle_cycles(3);
      for (int i = 0; i < 6; i++) cycle(1'b1);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_busy_before got=%b exp=1", busy);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({short_press, long_press, double_click, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset_immediate got=%b exp=0000", {short_press, long_press, double_click, busy});
      end
      do_reset_release();
      for (int i = 0; i < 17; i++) begin
         cycle(i < 15);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL mid_cyc%0d got=%b exp=%b", i, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
         if (long_press) longs++;
      end
      checks++;
      if (longs != 0) begin
         failures++;
         $display("FAIL mid_no_long got=%0d exp=0", longs);
      end
   endtask

   task automatic test_random();
      logic b = 1'b0;
      int run = 0;
      idle_cycles(3);
      for (int i = 0; i < 600; i++) begin
         if (run == 0) begin
            b   = ~b;
            run = $urandom_range(1, 11);
         end
         run--;
         cycle(b);
         checks++;
         if ({short_press, long_press, double_click, busy} !== {e_short, e_long, e_double, e_busy}) begin
            failures++;
            $display("FAIL random_cyc%0d btn=%b got=%b exp=%b", i, b, {short_press, long_press, double_click, busy},
                     {e_short, e_long, e_double, e_busy});
         end
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_double();
      test_boundary();
      test_reset_held();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
